// File: rtl/sync_fifo_stat.sv
// Synchronous FIFO with registered read data, occupancy count, programmable
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module sync_fifo_stat #(
    parameter int B      = 8,
    parameter int W      = 4,
    parameter int AF_LVL = 14,
    parameter int AE_LVL = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr,
    input  logic [B-1:0] w_data,
    input  logic         rd,
    output logic [B-1:0] r_data,
    output logic         valid,
    output logic         empty,
    output logic         full,
    output logic         almost_empty,
    output logic         almost_full,
    output logic [W:0]   count,
    output logic         overflow,
    output logic         underflow,
    input  logic         clr_err
);

    localparam int DEPTH = 1 << W;

    // Handshake: wr/rd are requests sampled on every rising edge; a request is
    // taken only when wr_acc/rd_acc is high, otherwise the matching sticky error
    // flag sets. A taken read shows up one cycle later as a one-cycle valid
    // pulse with the popped word on r_data.

    logic [B-1:0] mem [DEPTH];
    logic [W-1:0] w_ptr;
    logic [W-1:0] r_ptr;
    logic         rd_acc;
    logic         wr_acc;
    logic [W:0]   count_next;

    // A write into a full FIFO is allowed when a read frees a slot at the same edge.
    always_comb begin
        rd_acc     = rd & ~empty;
        wr_acc     = wr & (~full | rd_acc);
        count_next = count + {{W{1'b0}}, wr_acc} - {{W{1'b0}}, rd_acc};
    end

    // Storage is deliberately not reset; contents are discarded via pointers/count.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[w_ptr] <= w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_ptr        <= '0;
            r_ptr        <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            valid        <= 1'b0;
            r_data       <= '0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc) begin
                w_ptr <= w_ptr + 1'b1;
            end
            // Nonblocking read of mem returns the old word if the same slot is written now.
            if (rd_acc) begin
                r_data <= mem[r_ptr];
                r_ptr  <= r_ptr + 1'b1;
            end
            valid        <= rd_acc;
            count        <= count_next;
            empty        <= (count_next == '0);
            full         <= (count_next == (W+1)'(DEPTH));
            almost_empty <= (count_next <= (W+1)'(AE_LVL));
            almost_full  <= (count_next >= (W+1)'(AF_LVL));

            // A new error event takes priority over a same-cycle clear.
            if (wr & ~wr_acc) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (rd & ~rd_acc) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_stat.sv
// Bench for sync_fifo_stat (depth 4): directed scenarios plus random traffic
// compared against a queue-based model of the FIFO rules.
module tb_sync_fifo_stat;

    localparam int B      = 8;
    localparam int W      = 2;
    localparam int DEPTH  = 4;
    localparam int AF_LVL = 3;
    localparam int AE_LVL = 1;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         wr = 1'b0;
    logic [B-1:0] w_data = '0;
    logic         rd = 1'b0;
    logic         clr_err = 1'b0;
    logic [B-1:0] r_data;
    logic         valid, empty, full, almost_empty, almost_full;
    logic [W:0]   count;
    logic         overflow, underflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    logic [B-1:0] exp_q[$];
    logic [B-1:0] exp_rdata = '0;
    logic         exp_valid = 1'b0;
    logic         exp_ovf = 1'b0;
    logic         exp_udf = 1'b0;

    sync_fifo_stat #(.B(B), .W(W), .AF_LVL(AF_LVL), .AE_LVL(AE_LVL)) dut (
        .clk(clk), .reset(reset), .wr(wr), .w_data(w_data), .rd(rd),
        .r_data(r_data), .valid(valid), .empty(empty), .full(full),
        .almost_empty(almost_empty), .almost_full(almost_full), .count(count),
        .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    // One clock of stimulus; the model advances with the same rules as the spec.
    task automatic step(input logic w, input logic [B-1:0] d, input logic r, input logic c);
        logic racc, wacc;
        wr = w; w_data = d; rd = r; clr_err = c;
        racc = r && (exp_q.size() > 0);
        wacc = w && ((exp_q.size() < DEPTH) || racc);
        @(posedge clk);
        #1;
        if (racc) begin
            exp_rdata = exp_q.pop_front();
            exp_valid = 1'b1;
        end else begin
            exp_valid = 1'b0;
        end
        if (wacc) exp_q.push_back(d);
        if (w && !wacc) exp_ovf = 1'b1; else if (c) exp_ovf = 1'b0;
        if (r && !racc) exp_udf = 1'b1; else if (c) exp_udf = 1'b0;
        wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        exp_rdata = '0; exp_valid = 1'b0; exp_ovf = 1'b0; exp_udf = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0);
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end
        n_tests++; if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_ae: got %b expected 1", almost_empty); end
        n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end
        n_tests++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_af: got %b expected 0", almost_full); end
        n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid); end
        n_tests++; if (r_data !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h expected 00", r_data); end
        n_tests++; if ({overflow, underflow} !== 2'b00) begin n_fail++; $display("FAIL reset_err: got %b%b expected 00", overflow, underflow); end
    endtask

    task automatic test_fill();
        logic [B-1:0] d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, d[i], 1'b0, 1'b0);
            n_tests++; if (count !== 3'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, count, i + 1); end
            n_tests++; if (almost_empty !== ((i + 1) <= AE_LVL)) begin n_fail++; $display("FAIL fill_ae[%0d]: got %b expected %b", i, almost_empty, (i + 1) <= AE_LVL); end
            n_tests++; if (almost_full !== ((i + 1) >= AF_LVL)) begin n_fail++; $display("FAIL fill_af[%0d]: got %b expected %b", i, almost_full, (i + 1) >= AF_LVL); end
            n_tests++; if (full !== (i == 3)) begin n_fail++; $display("FAIL fill_full[%0d]: got %b expected %b", i, full, i == 3); end
        end
        step(1'b1, 8'h55, 1'b0, 1'b0);
        n_tests++; if (count !== 3'd4) begin n_fail++; $display("FAIL ovf_count: got %0d expected 4", count); end
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    endtask

    task automatic test_drain();
        logic [B-1:0] d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            n_tests++; if (valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid[%0d]: got %b expected 1", i, valid); end
            n_tests++; if (r_data !== d[i]) begin n_fail++; $display("FAIL drain_data[%0d]: got %h expected %h", i, r_data, d[i]); end
        end
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b expected 1", empty); end
        step(1'b0, '0, 1'b1, 1'b0);
        n_tests++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL udf_flag: got %b expected 1", underflow); end
        n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL udf_valid: got %b expected 0", valid); end
        n_tests++; if (r_data !== 8'h44) begin n_fail++; $display("FAIL udf_hold: got %h expected 44", r_data); end
        step(1'b0, '0, 1'b0, 1'b1);
        n_tests++; if ({overflow, underflow} !== 2'b00) begin n_fail++; $display("FAIL clr_err: got %b%b expected 00", overflow, underflow); end
    endtask

    task automatic test_full_rdwr();
        logic [B-1:0] d [4];
        for (int i = 0; i < 4; i++) begin
            d[i] = 8'($urandom_range(0, 255));
            step(1'b1, d[i], 1'b0, 1'b0);
        end
        step(1'b1, 8'hA5, 1'b1, 1'b0);
        n_tests++; if (valid !== 1'b1 || r_data !== d[0]) begin n_fail++; $display("FAIL fullrw_data: got %b/%h expected 1/%h", valid, r_data, d[0]); end
        n_tests++; if (count !== 3'd4 || full !== 1'b1) begin n_fail++; $display("FAIL fullrw_count: got %0d/%b expected 4/1", count, full); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fullrw_ovf: got %b expected 0", overflow); end
        for (int i = 1; i < 4; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            n_tests++; if (r_data !== d[i]) begin n_fail++; $display("FAIL fullrw_rest[%0d]: got %h expected %h", i, r_data, d[i]); end
        end
        step(1'b0, '0, 1'b1, 1'b0);
        n_tests++; if (valid !== 1'b1 || r_data !== 8'hA5) begin n_fail++; $display("FAIL fullrw_a5: got %b/%h expected 1/a5", valid, r_data); end
    endtask

    task automatic test_empty_rdwr();
        step(1'b1, 8'h5A, 1'b1, 1'b0);
        n_tests++; if (count !== 3'd1) begin n_fail++; $display("FAIL emptyrw_count: got %0d expected 1", count); end
        n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL emptyrw_valid: got %b expected 0", valid); end
        n_tests++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL emptyrw_udf: got %b expected 1", underflow); end
        step(1'b0, '0, 1'b1, 1'b0);
        n_tests++; if (valid !== 1'b1 || r_data !== 8'h5A) begin n_fail++; $display("FAIL emptyrw_data: got %b/%h expected 1/5a", valid, r_data); end
        // Set beats clear in the same cycle.
        step(1'b0, '0, 1'b1, 1'b1);
        n_tests++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL set_wins: got %b expected 1", underflow); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) step(1'b1, 8'(i + 1), 1'b0, 1'b0);
        reset_dut();
        n_tests++; if (count !== 3'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL midrst_state: got %0d/%b expected 0/1", count, empty); end
        step(1'b1, 8'h77, 1'b0, 1'b0);
        n_tests++; if (count !== 3'd1) begin n_fail++; $display("FAIL midrst_wr: got %0d expected 1", count); end
        step(1'b0, '0, 1'b1, 1'b0);
        n_tests++; if (count !== 3'd0 || r_data !== 8'h77) begin n_fail++; $display("FAIL midrst_rd: got %0d/%h expected 0/77", count, r_data); end
        step(1'b1, 8'h01, 1'b1, 1'b0);
        n_tests++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL midrst_udf: got %b expected 1", underflow); end
        step(1'b0, '0, 1'b1, 1'b1);
        n_tests++; if ({overflow, underflow} !== 2'b00) begin n_fail++; $display("FAIL midrst_clr: got %b%b expected 00", overflow, underflow); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
            step(1'b0, '0, 1'b1, 1'b0);
            n_tests++; if (valid !== 1'b1 || r_data !== 8'(8'h80 + i)) begin n_fail++; $display("FAIL wrap[%0d]: got %b/%h expected 1/%h", i, valid, r_data, 8'(8'h80 + i)); end
        end
    endtask

    task automatic test_random();
        reset_dut();
        for (int i = 0; i < 500; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 15) == 0));
            n_tests++;
            if (count !== 3'(exp_q.size()) || empty !== (exp_q.size() == 0) || full !== (exp_q.size() == DEPTH) ||
                almost_empty !== (exp_q.size() <= AE_LVL) || almost_full !== (exp_q.size() >= AF_LVL) ||
                valid !== exp_valid || r_data !== exp_rdata || overflow !== exp_ovf || underflow !== exp_udf) begin
                n_fail++;
                $display("FAIL random[%0d]: got cnt=%0d e=%b f=%b ae=%b af=%b v=%b d=%h o=%b u=%b expected cnt=%0d v=%b d=%h o=%b u=%b",
                         i, count, empty, full, almost_empty, almost_full, valid, r_data, overflow, underflow,
                         exp_q.size(), exp_valid, exp_rdata, exp_ovf, exp_udf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_full_rdwr();
        test_empty_rdwr();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
